sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares one toggle-handshake SDRAM port between two requesters:
//  CPU RAM / ROM download (A, high priority) and cassette reader (B).
//  Sits between the RAM mapper / cassette logic and one sdram port.
//  Frees the second sdram port for a future disk or cartridge path.
//  Each request is granted, issued, completed and acknowledged in turn.
// PARAMETERS
//  AW        25  address width, all ports
//  DW        16  data width, all ports
//  MAX_WAIT  4   consecutive A grants while B is pending before B is forced (fair mode only)
// PORTS
//  clk_sys    in   1   system clock; all logic on its rising edge
//  reset_n    in   1   asynchronous active-low reset
//  a_req      in   1   A request toggle; pending while a_req != a_ack
//  a_ack      out  1   A acknowledge toggle
//  a_we       in   1   A write (1) / read (0)
//  a_addr     in   AW  A address
//  a_ds       in   2   A byte strobes {upper,lower}
//  a_d        in   DW  A write data
//  a_q        out  DW  A read data; valid from the a_ack toggle until A's next grant
//  b_*        --   --  identical set for requester B (b_req,b_ack,b_we,b_addr,b_ds,b_d,b_q)
//  mem_req    out  1   SDRAM port request toggle
//  mem_ack    in   1   SDRAM port acknowledge toggle
//  mem_we     out  1   SDRAM write enable, held for the whole access
//  mem_addr   out  AW  SDRAM address, held
//  mem_ds     out  2   SDRAM byte strobes, held
//  mem_d      out  DW  SDRAM write data, held
//  mem_q      in   DW  SDRAM read data; valid when mem_ack == mem_req
//  busy       out  1   1 in any state other than IDLE
//  owner_b    out  1   1 while the current/last grant belongs to B
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all outputs 0: a_ack, b_ack, mem_req, mem_we, mem_addr, mem_ds, mem_d, a_q, b_q, busy, owner_b
//   - state IDLE, starvation counter 0
//   - the SDRAM controller is reset together, so mem_ack == 0
//   - requesters must return req to 0 on reset
//  FSM states: IDLE, ISSUE, WAIT, DONE.
//   IDLE: pend_a = a_req^a_ack, pend_b = b_req^b_ack.
//         Select a requester and latch its we/addr/ds/d into the mem_* registers.
//         Set owner_b. Go to ISSUE. Stay in IDLE if nothing is pending.
//   ISSUE: toggle mem_req, go to WAIT. One cycle.
//   WAIT: hold until mem_ack == mem_req.
//         On that cycle, if the access is a read, latch mem_q into a_q or b_q (per owner_b).
//         Go to DONE.
//   DONE: toggle the owner's ack, go to IDLE.
//  Latency and throughput:
//   - pending detected in cycle N -> mem_req toggles N+2 -> owner ack toggles 1 cycle after mem_ack matches.
//   - minimum 4 cycles plus SDRAM latency per access.
//   - back-to-back requests are never pipelined; at most one access is outstanding.
//  Arbitration: when both are pending in IDLE, A wins unless fairness forces B (see CONFIGURATION).
//  Requester rules:
//   - a requester must not toggle req again until its ack matches.
//   - a second toggle while pending is illegal; the arbiter cancels nothing.
//   - inputs may change freely once the grant has latched them (first IDLE->ISSUE cycle).
//  Simultaneous events:
//   - new requests arriving during ISSUE/WAIT/DONE are sampled only in IDLE.
//   - a_q/b_q of the non-owner never change.
//   - mem_ack is ignored outside WAIT.
//  Reset mid-access: all state returns to IDLE; the in-flight access is abandoned.
//   The SDRAM controller must be reset simultaneously.
// CONFIGURATION
//  SDRAM_ARB_FAIR_EN defined:
//   - 3-bit counter, saturating at MAX_WAIT; increments on each A grant while pend_b == 1.
//   - clears on any B grant.
//   - in IDLE, counter == MAX_WAIT with B pending -> B wins, even if A is pending.
//  SDRAM_ARB_FAIR_EN undefined:
//   - strict priority; B is served only when A is not pending.
//   - no counter logic is synthesised.
// TESTING
//  1 Reset: reset_n=0 mid-WAIT
//    -> next edge all outputs 0, busy=0, state IDLE; mem_req stays 0 after release.
//  2 Single A read: a_req 0->1, a_addr=0x000123, mem_q=0xBEEF, mem_ack toggles 5 cycles after mem_req
//    -> mem_addr=0x000123 and mem_we=0 while busy; a_q=0xBEEF; a_ack=1; b_ack unchanged.
//  3 Single B write: b_req toggle, b_addr=0x1800010, b_d=0x5A5A, b_ds=2'b01
//    -> mem_we=1, mem_d=0x5A5A, mem_ds=01; b_ack toggles; b_q unchanged.
//  4 Simultaneous A+B pending, strict build
//    -> A served first, B next; owner_b sequence 0,1; two mem_req toggles total.
//  5 Fair build, MAX_WAIT=4: B held pending, A re-toggles immediately after every ack
//    -> exactly 4 A grants, then 1 B grant, then A resumes.
//    Strict build, same stimulus -> B never granted while A keeps re-toggling.
//  6 Late mem_ack: hold mem_ack 50 cycles
//    -> a_ack/b_ack unchanged; new b_req toggle meanwhile is served only after A's DONE.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-requester toggle-handshake SDRAM port arbiter
//
// Purpose:
//   Shares one toggle-handshake SDRAM port between requester A (CPU RAM /
//   ROM download, high priority) and requester B (cassette reader). Each
//   access is granted, issued, completed and acknowledged in turn. Only one
//   access is ever outstanding.
//
// Optional feature macro: SDRAM_ARB_FAIR_EN
//   When defined, B is forced through after MAX_WAIT consecutive A grants
//   that happened while B was pending. When undefined, priority is strict.
//
// Ports:
//   clk_sys, reset_n            clock, asynchronous active-low reset
//   a_req/a_ack                 A toggle handshake (pending while they differ)
//   a_we/a_addr/a_ds/a_d        A access attributes, latched at grant
//   a_q                         A read data, valid from a_ack toggle
//   b_*                         same set for requester B
//   mem_req/mem_ack             SDRAM toggle handshake
//   mem_we/mem_addr/mem_ds/mem_d  SDRAM access attributes, held per access
//   mem_q                       SDRAM read data, valid when mem_ack == mem_req
//   busy                        1 outside IDLE
//   owner_b                     1 while the current/last grant belongs to B
module sdram_port_arbiter #(
  parameter int AW       = 25,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          a_req,
  output logic          a_ack,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [1:0]    a_ds,
  input  logic [DW-1:0] a_d,
  output logic [DW-1:0] a_q,
  input  logic          b_req,
  output logic          b_ack,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [1:0]    b_ds,
  input  logic [DW-1:0] b_d,
  output logic [DW-1:0] b_q,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_ds,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q,
  output logic          busy,
  output logic          owner_b
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  logic          r_a_ack;
  logic          r_b_ack;
  logic [DW-1:0] r_a_q;
  logic [DW-1:0] r_b_q;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [1:0]    r_mem_ds;
  logic [DW-1:0] r_mem_d;
  logic          r_busy;
  logic          r_owner_b;

  logic w_pend_a;
  logic w_pend_b;
  logic w_pick_b;
  logic w_grant;

  assign w_pend_a = a_req ^ r_a_ack;
  assign w_pend_b = b_req ^ r_b_ack;
  assign w_grant  = (r_state == S_IDLE) && (w_pend_a || w_pend_b);

`ifdef SDRAM_ARB_FAIR_EN
  localparam logic [2:0] LP_MAX_WAIT = 3'(MAX_WAIT);

  // Counts A grants taken while B was waiting; at the limit B jumps ahead.
  logic [2:0] r_wait_cnt;

  assign w_pick_b = w_pend_b && (!w_pend_a || (r_wait_cnt == LP_MAX_WAIT));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= 3'd0;
    end else if (w_grant) begin
      if (w_pick_b) begin
        r_wait_cnt <= 3'd0;
      end else if (w_pend_b && (r_wait_cnt != LP_MAX_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + 3'd1;
      end
    end
  end
`else
  logic w_unused_max_wait;

  assign w_pick_b          = w_pend_b && !w_pend_a;
  assign w_unused_max_wait = |3'(MAX_WAIT);
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_a_q      <= '0;
      r_b_q      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_ds   <= 2'b00;
      r_mem_d    <= '0;
      r_busy     <= 1'b0;
      r_owner_b  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            // Attributes are captured here so requesters may change them freely afterwards.
            r_owner_b  <= w_pick_b;
            r_mem_we   <= w_pick_b ? b_we   : a_we;
            r_mem_addr <= w_pick_b ? b_addr : a_addr;
            r_mem_ds   <= w_pick_b ? b_ds   : a_ds;
            r_mem_d    <= w_pick_b ? b_d    : a_d;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mem_req <= ~r_mem_req;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_ack == r_mem_req) begin
            if (!r_mem_we) begin
              if (r_owner_b) r_b_q <= mem_q;
              else           r_a_q <= mem_q;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_owner_b) r_b_ack <= ~r_b_ack;
          else           r_a_ack <= ~r_a_ack;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a_ack    = r_a_ack;
  assign b_ack    = r_b_ack;
  assign a_q      = r_a_q;
  assign b_q      = r_b_q;
  assign mem_req  = r_mem_req;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_ds   = r_mem_ds;
  assign mem_d    = r_mem_d;
  assign busy     = r_busy;
  assign owner_b  = r_owner_b;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int MAX_WAIT = 4;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          a_req, a_ack, a_we, b_req, b_ack, b_we;
  logic [AW-1:0] a_addr, b_addr, mem_addr;
  logic [1:0]    a_ds, b_ds, mem_ds;
  logic [DW-1:0] a_d, b_d, a_q, b_q, mem_d, mem_q;
  logic          mem_req, mem_ack, mem_we, busy, owner_b;

  always #5 clk_sys = ~clk_sys;

  sdram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .a_req(a_req), .a_ack(a_ack), .a_we(a_we), .a_addr(a_addr), .a_ds(a_ds), .a_d(a_d), .a_q(a_q),
    .b_req(b_req), .b_ack(b_ack), .b_we(b_we), .b_addr(b_addr), .b_ds(b_ds), .b_d(b_d), .b_q(b_q),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ds(mem_ds),
    .mem_d(mem_d), .mem_q(mem_q), .busy(busy), .owner_b(owner_b)
  );

  typedef struct packed {
    logic          owner;
    logic          we;
    logic [AW-1:0] addr;
    logic [1:0]    ds;
    logic [DW-1:0] d;
  } acc_t;

  int   total = 0;
  int   bad = 0;
  int   lat_cfg = 0;
  int   held_err = 0;
  acc_t grant_log[$];
  logic [DW-1:0] sd_mem [logic [AW-1:0]];
  logic [DW-1:0] model_mem [logic [AW-1:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [1:0] ds);
    return {ds[1] ? nw[15:8] : old[15:8], ds[0] ? nw[7:0] : old[7:0]};
  endfunction

  function automatic logic [DW-1:0] sd_rd(input logic [AW-1:0] a);
    return sd_mem.exists(a) ? sd_mem[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a);
  endfunction

  function automatic acc_t bus_now();
    acc_t t;
    t.owner = owner_b; t.we = mem_we; t.addr = mem_addr; t.ds = mem_ds; t.d = mem_d;
    return t;
  endfunction

  // SDRAM port model: toggle handshake with a programmable latency.
  initial begin : sdram_model
    int   cnt;
    int   lat;
    bit   seen;
    acc_t cur;
    mem_ack = 1'b0; mem_q = '0; seen = 0; cnt = 0; lat = 0; cur = '0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        mem_ack = 1'b0;
        seen = 0;
      end else if (mem_req != mem_ack) begin
        if (!seen) begin
          seen = 1; cnt = 0; cur = bus_now();
          grant_log.push_back(cur);
          lat = (lat_cfg < 0) ? int'($urandom_range(3, 0)) : lat_cfg;
        end else begin
          cnt++;
        end
        if (cnt >= lat) begin
          if (bus_now() != cur) held_err++;
          if (mem_we) sd_mem[mem_addr] = merge(sd_rd(mem_addr), mem_d, mem_ds);
          else        mem_q = sd_rd(mem_addr);
          mem_ack = mem_req;
          seen = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic wait_ack(input string tag, input bit is_b, input logic exp, input int budget,
                          output int n);
    n = 0;
    while (((is_b ? b_ack : a_ack) !== exp) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, is_b ? b_ack : a_ack, exp);
  endtask

  acc_t a_txn, b_txn;

  task automatic complete(input bit is_b);
    acc_t g;
    acc_t t;
    t = is_b ? b_txn : a_txn;
    if (grant_log.size() == 0) begin
      chk("rnd_grant_present", 0, 1);
      return;
    end
    g = grant_log.pop_front();
    chk("rnd_owner", g.owner, is_b);
    chk("rnd_fields", {g.we, g.addr, g.ds, g.d}, {t.we, t.addr, t.ds, t.d});
    if (!t.we) chk("rnd_rdata", is_b ? b_q : a_q, model_rd(t.addr));
    else       model_mem[t.addr] = merge(model_rd(t.addr), t.d, t.ds);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : main
    int n1, n2, issued, done;
    logic sa, sb, pa, pb;
    logic [6:0] exp_own;

    reset_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_ds = 0; a_d = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_ds = 0; b_d = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_ctrl", {a_ack, b_ack, mem_req, mem_we, busy, owner_b, mem_ds}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", {mem_d, a_q, b_q}, 0);

    // 1: reset asserted while an access waits on the SDRAM
    lat_cfg = 20;
    a_we = 0; a_addr = 25'h77; a_ds = 2'b11; a_req = 1;
    n1 = 0;
    while (mem_req !== 1'b1 && n1 < 10) begin tick(); n1++; end
    tick(); tick();
    chk("t1_busy_in_wait", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("t1_async_ctrl", {a_ack, b_ack, mem_req, mem_we, busy, owner_b, mem_ds}, 0);
    chk("t1_async_data", {mem_addr, mem_d, a_q, b_q}, 0);
    a_req = 0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("t1_post_release", {mem_req, busy, a_ack}, 0);
    grant_log.delete();

    // 2: single A read with 5-cycle SDRAM latency
    lat_cfg = 5;
    sd_mem[25'h000123] = 16'hBEEF;
    a_we = 0; a_addr = 25'h000123; a_ds = 2'b11; a_d = 16'h0;
    a_req = 1;
    n1 = 0;
    while (mem_req !== 1'b1 && n1 < 10) begin tick(); n1++; end
    chk("t2_issue_latency", n1, 2);
    chk("t2_mem_addr", mem_addr, 25'h000123);
    chk("t2_mem_we_busy", {mem_we, busy}, 2'b01);
    wait_ack("t2_a_ack", 0, 1'b1, 30, n2);
    chk("t2_total_latency", n1 + n2, 9);
    chk("t2_a_q", a_q, 16'hBEEF);
    chk("t2_b_ack", b_ack, 0);
    chk("t2_grants", grant_log.size(), 1);

    // 3: single B write
    grant_log.delete();
    lat_cfg = 2;
    b_we = 1; b_addr = 25'h1800010; b_d = 16'h5A5A; b_ds = 2'b01;
    b_req = 1;
    tick(); tick(); tick();
    b_d = 16'hFFFF; b_addr = 25'h0;
    wait_ack("t3_b_ack", 1, 1'b1, 30, n2);
    chk("t3_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) begin
      chk("t3_fields", {grant_log[0].owner, grant_log[0].we, grant_log[0].addr, grant_log[0].ds,
                        grant_log[0].d}, {1'b1, 1'b1, 25'h1800010, 2'b01, 16'h5A5A});
    end
    chk("t3_sdram_word", sd_rd(25'h1800010), 16'hA55A);
    chk("t3_q_unchanged", {a_q, b_q}, {16'hBEEF, 16'h0000});

    // 4: A and B pending together
    grant_log.delete();
    lat_cfg = 1;
    a_we = 1; a_addr = 25'h42; a_d = 16'h1357; a_ds = 2'b11;
    b_we = 0; b_addr = 25'h42;
    a_req = 0; b_req = 0;
    wait_ack("t4_a_ack", 0, 1'b0, 30, n2);
    wait_ack("t4_b_ack", 1, 1'b0, 30, n2);
    chk("t4_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) chk("t4_owner_seq", {grant_log[0].owner, grant_log[1].owner}, 2'b01);
    chk("t4_b_q", b_q, 16'h1357);
    chk("t4_a_q", a_q, 16'hBEEF);

    // 5: B held pending while A re-toggles after every ack
`ifdef SDRAM_ARB_FAIR_EN
    exp_own = 7'b0010000;
`else
    exp_own = 7'b1000000;
`endif
    grant_log.delete();
    lat_cfg = 0;
    a_we = 0; a_addr = 25'h66; b_we = 0; b_addr = 25'h55;
    a_req = ~a_req; b_req = ~b_req;
    for (int k = 0; k < 6; k++) begin
      wait_ack("t5_a_ack", 0, a_req, 40, n2);
      if (k < 5) a_req = ~a_req;
    end
    wait_ack("t5_b_ack", 1, b_req, 40, n2);
    chk("t5_grants", grant_log.size(), 7);
    for (int k = 0; k < 7; k++) begin
      if (k < grant_log.size()) chk($sformatf("t5_owner_%0d", k), grant_log[k].owner, exp_own[k]);
    end

    // 6: SDRAM stalls 50 cycles; a B request arrives meanwhile
    grant_log.delete();
    lat_cfg = 50;
    sa = a_ack; sb = b_ack;
    a_we = 0; a_addr = 25'h000123; a_req = ~a_req;
    repeat (10) tick();
    b_we = 1; b_addr = 25'h99; b_d = 16'hCAFE; b_ds = 2'b11; b_req = ~b_req;
    lat_cfg = 2;
    repeat (35) tick();
    chk("t6_acks_held", {a_ack, b_ack}, {sa, sb});
    chk("t6_one_grant", grant_log.size(), 1);
    wait_ack("t6_a_ack", 0, ~sa, 80, n2);
    chk("t6_b_after_a", b_ack, sb);
    wait_ack("t6_b_ack", 1, ~sb, 30, n2);
    if (grant_log.size() == 2) chk("t6_owner_seq", {grant_log[0].owner, grant_log[1].owner}, 2'b01);
    else chk("t6_grants", grant_log.size(), 2);
    chk("t6_a_q", a_q, 16'hBEEF);

    // Random traffic against a memory-level reference
    grant_log.delete();
    lat_cfg = -1;
    issued = 0; done = 0;
    pa = a_ack; pb = b_ack;
    for (int c = 0; c < 600; c++) begin
      if (a_ack !== pa) begin complete(0); done++; pa = a_ack; end
      if (b_ack !== pb) begin complete(1); done++; pb = b_ack; end
      if (c < 520 && a_req == a_ack && $urandom_range(2, 0) == 0) begin
        a_we = 1'($urandom); a_addr = 25'h200 + 25'($urandom_range(7, 0));
        a_ds = 2'($urandom); a_d = 16'($urandom);
        a_txn = '{1'b0, a_we, a_addr, a_ds, a_d};
        a_req = ~a_req; issued++;
      end
      if (c < 520 && b_req == b_ack && $urandom_range(2, 0) == 0) begin
        b_we = 1'($urandom); b_addr = 25'h200 + 25'($urandom_range(7, 0));
        b_ds = 2'($urandom); b_d = 16'($urandom);
        b_txn = '{1'b1, b_we, b_addr, b_ds, b_d};
        b_req = ~b_req; issued++;
      end
      tick();
    end
    chk("rnd_all_done", done, issued);
    chk("rnd_no_extra_grants", grant_log.size(), 0);
    chk("held_attributes", held_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
